// File: rtl/nav_autopilot.sv
`default_nettype none
// ============================================================================
//  Module   : nav_autopilot
//  Purpose  : Waypoint command driver for the three-axis position datapath;
//             emits pos_mode/jump_position/velocity and mirrors ship position.
//  Revision : 1.0  initial release
// ============================================================================
module nav_autopilot #(
   parameter int K           = 16,
   parameter int MAX_STEP    = 4,
   parameter int JUMP_THRESH = 100
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [3*K-1:0] cmd_target,
   input  logic           cmd_jump_en,
   input  logic           abort,
   output logic [3:0]     pos_mode,
   output logic [3*K-1:0] jump_position,
   output logic [3*K-1:0] velocity,
   output logic [3*K-1:0] cur_position,
   output logic           busy,
   output logic           done
);

   localparam logic [3:0]   c_MODE_ZERO   = 4'b0001;
   localparam logic [3:0]   c_MODE_STEP   = 4'b0010;
   localparam logic [3:0]   c_MODE_JUMP   = 4'b0100;
   localparam logic [K-1:0] c_MAX_STEP    = K'(MAX_STEP);
   localparam logic [K-1:0] c_NEG_STEP    = K'(-MAX_STEP);
   localparam logic [K-1:0] c_JUMP_THRESH = K'(JUMP_THRESH);

   typedef enum logic [2:0] {
      ST_ZERO   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_CRUISE = 3'd2,
      ST_JUMP   = 3'd3,
      ST_ARRIVE = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [3*K-1:0]  r_shadow;
   logic [3*K-1:0]  r_target;
   logic            r_jump_en;

   logic [3*K-1:0]  w_step;
   logic [3*K-1:0]  w_shadow_sum;
   logic [2:0]      w_axis_zero;
   logic [2:0]      w_axis_far;
   logic            w_at_target;
   logic            w_far;

   // Per-axis distance is taken modulo 2^K so the signed view is the shortest wrap path.
   for (genvar a = 0; a < 3; a++) begin : g_axis
      logic [K-1:0] w_d;
      logic [K-1:0] w_mag;
      logic [K-1:0] w_acc_d;
      logic [K-1:0] w_acc_mag;

      assign w_d       = r_target[a*K +: K] - r_shadow[a*K +: K];
      assign w_mag     = w_d[K-1] ? (~w_d + K'(1)) : w_d;
      assign w_acc_d   = cmd_target[a*K +: K] - r_shadow[a*K +: K];
      assign w_acc_mag = w_acc_d[K-1] ? (~w_acc_d + K'(1)) : w_acc_d;

      assign w_step[a*K +: K]       = (w_mag <= c_MAX_STEP) ? w_d
                                    : (w_d[K-1] ? c_NEG_STEP : c_MAX_STEP);
      assign w_shadow_sum[a*K +: K] = r_shadow[a*K +: K] + velocity[a*K +: K];
      assign w_axis_zero[a]         = (w_d == '0);
      assign w_axis_far[a]          = (w_acc_mag > c_JUMP_THRESH);
   end

   assign w_at_target  = &w_axis_zero;
   assign w_far        = |w_axis_far;
   assign cur_position = r_shadow;

   always_comb begin
      w_state_next  = r_state;
      pos_mode      = c_MODE_STEP;
      velocity      = '0;
      jump_position = '0;
      cmd_ready     = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (r_state)
         ST_ZERO: begin
            pos_mode     = c_MODE_ZERO;
            w_state_next = ST_IDLE;
         end
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_state_next = (cmd_jump_en && w_far) ? ST_JUMP : ST_CRUISE;
            end
         end
         ST_CRUISE: begin
            busy     = 1'b1;
            velocity = w_step;
            if (abort) begin
               w_state_next = ST_IDLE;
            end else if (w_at_target) begin
               w_state_next = ST_ARRIVE;
            end
         end
         ST_JUMP: begin
            busy = 1'b1;
            // The latched permission gates the jump so no path can jump without it.
            if (r_jump_en) begin
               pos_mode      = c_MODE_JUMP;
               jump_position = r_target;
            end
            w_state_next = abort ? ST_IDLE : ST_ARRIVE;
         end
         ST_ARRIVE: begin
            done         = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            pos_mode     = c_MODE_ZERO;
            w_state_next = ST_ZERO;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_ZERO;
         r_shadow  <= '0;
         r_target  <= '0;
         r_jump_en <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (pos_mode)
            c_MODE_ZERO: r_shadow <= '0;
            c_MODE_JUMP: r_shadow <= jump_position;
            default:     r_shadow <= w_shadow_sum;
         endcase
         if (cmd_valid && cmd_ready) begin
            r_target  <= cmd_target;
            r_jump_en <= cmd_jump_en;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_nav_autopilot.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nav_autopilot
//  Purpose  : Self-checking bench; each command is turned into a planned
//             cycle-by-cycle trace from waypoint arithmetic and compared.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nav_autopilot;

   localparam int K  = 16;
   localparam int MS = 4;
   localparam int JT = 100;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           cmd_valid = 1'b0;
   logic           cmd_ready;
   logic [3*K-1:0] cmd_target = '0;
   logic           cmd_jump_en = 1'b0;
   logic           abort = 1'b0;
   logic [3:0]     pos_mode;
   logic [3*K-1:0] jump_position;
   logic [3*K-1:0] velocity;
   logic [3*K-1:0] cur_position;
   logic           busy;
   logic           done;

   int checks   = 0;
   int failures = 0;
   logic [3*K-1:0] mpos = '0;

   localparam logic [3*K-1:0] c_JUNK = {16'd50, 16'd50, 16'd50};

   typedef struct {
      logic [6:0]     ctrl;
      logic [3*K-1:0] vel;
      logic [3*K-1:0] jp;
      logic [3*K-1:0] cur;
      bit             ab;
      bit             rs;
      bit             jk;
   } exp_t;

   nav_autopilot #(.K(K), .MAX_STEP(MS), .JUMP_THRESH(JT)) dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_target    (cmd_target),
      .cmd_jump_en   (cmd_jump_en),
      .abort         (abort),
      .pos_mode      (pos_mode),
      .jump_position (jump_position),
      .velocity      (velocity),
      .cur_position  (cur_position),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   function automatic logic [K-1:0] ax(input logic [3*K-1:0] v, input int a);
      return v[a*K +: K];
   endfunction

   function automatic int sdiff(input logic [K-1:0] t, input logic [K-1:0] p);
      logic [K-1:0] d;
      d = t - p;
      return int'($signed(d));
   endfunction

   // Velocity per axis: shortest signed distance clipped to +/-MS.
   function automatic logic [3*K-1:0] clamp3(input logic [3*K-1:0] t, input logic [3*K-1:0] p);
      logic [3*K-1:0] r;
      int d;
      for (int a = 0; a < 3; a++) begin
         d = sdiff(ax(t, a), ax(p, a));
         if (d > MS) d = MS;
         if (d < -MS) d = -MS;
         r[a*K +: K] = d[K-1:0];
      end
      return r;
   endfunction

   function automatic logic [3*K-1:0] add3(input logic [3*K-1:0] x, input logic [3*K-1:0] y);
      logic [3*K-1:0] r;
      for (int a = 0; a < 3; a++) r[a*K +: K] = ax(x, a) + ax(y, a);
      return r;
   endfunction

   function automatic exp_t mk(input logic [6:0] c, input logic [3*K-1:0] v,
                               input logic [3*K-1:0] j, input logic [3*K-1:0] p);
      exp_t e;
      e.ctrl = c; e.vel = v; e.jp = j; e.cur = p;
      e.ab = 1'b0; e.rs = 1'b0; e.jk = 1'b0;
      return e;
   endfunction

   // ctrl = {pos_mode, busy, done, cmd_ready}
   localparam logic [6:0] c_IDLE   = {4'b0010, 1'b0, 1'b0, 1'b1};
   localparam logic [6:0] c_CRUISE = {4'b0010, 1'b1, 1'b0, 1'b0};
   localparam logic [6:0] c_JUMPC  = {4'b0100, 1'b1, 1'b0, 1'b0};
   localparam logic [6:0] c_ARRIVE = {4'b0010, 1'b0, 1'b1, 1'b0};
   localparam logic [6:0] c_ZEROC  = {4'b0001, 1'b0, 1'b0, 1'b0};

   // Plans the whole command from waypoint arithmetic, then plays it against the DUT.
   task automatic run_cmd(input string name, input logic [3*K-1:0] tgt, input bit jen,
                          input int abort_at, input int rst_at, input int junk_at);
      exp_t plan[$];
      exp_t e;
      logic [3*K-1:0] p, v;
      bit do_jump;
      p = mpos;
      do_jump = 1'b0;
      for (int a = 0; a < 3; a++) begin
         int d;
         d = sdiff(ax(tgt, a), ax(p, a));
         if (jen && (d > JT || d < -JT)) do_jump = 1'b1;
      end
      plan.push_back(mk(c_IDLE, '0, '0, p));
      if (do_jump) begin
         e = mk(c_JUMPC, '0, tgt, p);
         e.ab = (abort_at == 0);
         e.rs = (rst_at == 0);
         plan.push_back(e);
         if (rst_at == 0) begin
            p = '0;
            plan.push_back(mk(c_ZEROC, '0, '0, p));
         end else begin
            p = tgt;
            if (abort_at != 0) plan.push_back(mk(c_ARRIVE, '0, '0, p));
         end
         plan.push_back(mk(c_IDLE, '0, '0, p));
      end else begin
         for (int n = 0; n < 9000; n++) begin
            v = clamp3(tgt, p);
            e = mk(c_CRUISE, v, '0, p);
            e.ab = (abort_at == n);
            e.rs = (rst_at == n);
            e.jk = (junk_at == n);
            plan.push_back(e);
            if (rst_at == n) begin
               p = '0;
               plan.push_back(mk(c_ZEROC, '0, '0, p));
               plan.push_back(mk(c_IDLE, '0, '0, p));
               break;
            end
            p = add3(p, v);
            if (abort_at == n) begin
               plan.push_back(mk(c_IDLE, '0, '0, p));
               break;
            end
            if (v == '0) begin
               plan.push_back(mk(c_ARRIVE, '0, '0, p));
               plan.push_back(mk(c_IDLE, '0, '0, p));
               break;
            end
         end
      end
      mpos = p;

      @(negedge clk);
      for (int i = 0; i < plan.size(); i++) begin
         checks++;
         if ({pos_mode, busy, done, cmd_ready} !== plan[i].ctrl) begin
            failures++;
            $display("FAIL %s ctrl cyc%0d: got mode/busy/done/ready=%b want %b",
                     name, i, {pos_mode, busy, done, cmd_ready}, plan[i].ctrl);
         end
         checks++;
         if ({velocity, jump_position, cur_position} !== {plan[i].vel, plan[i].jp, plan[i].cur}) begin
            failures++;
            $display("FAIL %s data cyc%0d: got vel=%h jp=%h cur=%h want vel=%h jp=%h cur=%h",
                     name, i, velocity, jump_position, cur_position,
                     plan[i].vel, plan[i].jp, plan[i].cur);
         end
         cmd_valid   = (i == 0) || plan[i].jk;
         cmd_target  = plan[i].jk ? c_JUNK : tgt;
         cmd_jump_en = (i == 0) ? jen : 1'b1;
         abort       = plan[i].ab;
         rst         = plan[i].rs;
         if (i < plan.size() - 1) @(negedge clk);
      end
      cmd_valid = 1'b0;
      abort     = 1'b0;
      rst       = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mpos = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (pos_mode !== 4'b0001 || cur_position !== '0) begin
            failures++;
            $display("FAIL reset_hold: got mode=%b cur=%h want 0001/0", pos_mode, cur_position);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({pos_mode, busy, done, cmd_ready} !== c_ZEROC || velocity !== '0) begin
         failures++;
         $display("FAIL reset_zero_cycle: got ctrl=%b vel=%h want %b/0",
                  {pos_mode, busy, done, cmd_ready}, velocity, c_ZEROC);
      end
      @(negedge clk);
      checks++;
      if ({pos_mode, busy, done, cmd_ready} !== c_IDLE || velocity !== '0 || cur_position !== '0) begin
         failures++;
         $display("FAIL reset_idle: got ctrl=%b vel=%h cur=%h want %b/0/0",
                  {pos_mode, busy, done, cmd_ready}, velocity, cur_position, c_IDLE);
      end
      mpos = '0;
   endtask

   task automatic test_cruise();
      run_cmd("cruise_10_0_3", {16'd10, 16'd0, 16'd3}, 1'b0, -1, -1, -1);
      run_cmd("cruise_same", {16'd10, 16'd0, 16'd3}, 1'b0, -1, -1, -1);
      checks++;
      if (cur_position !== {16'd10, 16'd0, 16'd3}) begin
         failures++;
         $display("FAIL cruise_final_pos: got %h want 000a00000003", cur_position);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      run_cmd("wrap_fffe", {16'hFFFE, 16'd0, 16'd0}, 1'b0, -1, -1, -1);
      do_reset();
      run_cmd("half_range", {16'h8000, 16'd0, 16'd0}, 1'b0, 3, -1, -1);
   endtask

   task automatic test_jump();
      do_reset();
      run_cmd("jump_1000", {16'd1000, 16'd0, 16'd0}, 1'b1, -1, -1, -1);
      do_reset();
      run_cmd("jump_en_near_50", {16'd50, 16'd0, 16'd0}, 1'b1, -1, -1, -1);
      do_reset();
      run_cmd("thresh_100", {16'd0, 16'd100, 16'd0}, 1'b1, -1, -1, -1);
      do_reset();
      run_cmd("thresh_m101", {16'd0, 16'd0, 16'hFF9B}, 1'b1, -1, -1, -1);
      run_cmd("far_no_jump_en", {16'd0, 16'd0, 16'd0}, 1'b0, -1, -1, -1);
   endtask

   task automatic test_abort();
      do_reset();
      run_cmd("abort_cruise", {16'd10, 16'd0, 16'd3}, 1'b0, 1, -1, -1);
      do_reset();
      run_cmd("rst_cruise", {16'd10, 16'd0, 16'd3}, 1'b0, -1, 1, -1);
      run_cmd("abort_jump", {16'd2000, 16'd7, 16'd0}, 1'b1, 0, -1, -1);
      run_cmd("rst_jump", {16'd9000, 16'd0, 16'd0}, 1'b1, -1, 0, -1);
   endtask

   task automatic test_ignore_valid();
      do_reset();
      run_cmd("valid_in_cruise", {16'd10, 16'd0, 16'd3}, 1'b0, -1, -1, 1);
   endtask

   task automatic test_random();
      for (int r = 0; r < 40; r++) begin
         logic [3*K-1:0] tgt;
         logic [63:0]    rnd;
         bit             jen;
         int             ab, rs, jk, off;
         jen = 1'($urandom_range(0, 1));
         if (jen && ($urandom_range(0, 1) == 1)) begin
            rnd = {$urandom(), $urandom()};
            tgt = rnd[3*K-1:0];
         end else begin
            for (int a = 0; a < 3; a++) begin
               off = int'($urandom_range(0, 300)) - 150;
               tgt[a*K +: K] = ax(mpos, a) + off[K-1:0];
            end
         end
         ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
         rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
         jk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
         run_cmd("random", tgt, jen, ab, rs, jk);
      end
   endtask

   initial begin
      test_reset();
      test_cruise();
      test_wrap();
      test_jump();
      test_abort();
      test_ignore_valid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nav_autopilot.md
Name: nav_autopilot

Overview:
Command-side driver for the three-axis position datapath. It accepts a target waypoint {X,Y,Z} over a valid/ready handshake. It keeps a shadow copy of ship position that updates exactly as the position registers do. Each cycle it emits pos_mode, jump_position and a signed per-axis velocity so the position datapath reaches the waypoint by sublight stepping or by a single jump.

Parameters:
k, 16, width of each axis coordinate and velocity word
MAX_STEP, 4, maximum per-cycle velocity magnitude per axis; must be less than 2^(k-1)
JUMP_THRESH, 100, minimum distance on any axis (strictly greater than) that permits a jump

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  waypoint command valid
cmd_ready  out  1  high only in IDLE
cmd_target  in  3k  waypoint {X,Y,Z}, X in the top k bits
cmd_jump_en  in  1  jump allowed for this command; sampled at acceptance
abort  in  1  cancel the current command
pos_mode  out  4  one-hot: 0001 zero/reset, 0010 sublight (pos+vel), 0100 jump
jump_position  out  3k  jump target {X,Y,Z}; zero unless pos_mode=0100
velocity  out  3k  two's-complement per-axis step {X,Y,Z}
cur_position  out  3k  shadow position {X,Y,Z}
busy  out  1  high in CRUISE or JUMP
done  out  1  one-cycle arrival pulse

Behaviour:
- Reset and clocking: one clock; reset is synchronous and active-high (clk, rst).
- rst=1 at a rising edge sets: state=ZERO, shadow=0, latched target=0, jump flag=0. This is legal at any time, including mid-command. No done pulse is issued for an interrupted command.
- State outputs (combinational from registered state, shadow and target):
  - ZERO: pos_mode=0001, velocity=0, cmd_ready=0, busy=0, done=0. Shadow is forced to 0. Next state IDLE. The first cycle after reset release is always ZERO.
  - IDLE: pos_mode=0010, velocity=0 (hold), cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_target and cmd_jump_en.
    - Next state is JUMP if jump_en=1 and any axis has |d| > JUMP_THRESH; otherwise CRUISE.
    - d is computed from cmd_target and the shadow at the accept edge.
  - CRUISE: pos_mode=0010, busy=1.
    - Per axis, d = (target - shadow) mod 2^k, interpreted as signed k-bit (shortest wrap path).
    - v = d if |d| <= MAX_STEP, else +MAX_STEP or -MAX_STEP by sign of d. d = -2^(k-1) clamps to -MAX_STEP.
    - When all three d = 0, v=0 and next state is ARRIVE.
  - JUMP: pos_mode=0100 for exactly one cycle, jump_position=target, velocity=0, busy=1. Next state ARRIVE.
  - ARRIVE: done=1 for one cycle, pos_mode=0010, velocity=0, cmd_ready=0. Next state IDLE.
- Shadow update at every edge:
  - 0001 -> 0
  - 0010 -> shadow+velocity per axis, modulo 2^k, wrapping
  - 0100 -> jump_position
  - cur_position equals the downstream position registers on every cycle.
- abort=1 in CRUISE or JUMP: next state IDLE, no done pulse. Any step or jump presented that same cycle still takes effect. abort is ignored in other states.
- cmd_valid while cmd_ready=0 is ignored, not queued. The target is stable during a command.
- Precedence: rst > abort > normal transitions.
- Latency:
  - Accept at edge T. The first command-driven output is on cycle T+1.
  - Jump: done on T+2.
  - Cruise: done one cycle after the cycle with all d=0.
  - Target equal to the shadow at accept: CRUISE on T+1 with v=0, done on T+2.

Test Plan:
1. Reset held 3 cycles, then released -> pos_mode=0001 for exactly one cycle, then 0010 with velocity=0, cmd_ready=1, cur_position=0.
2. From (0,0,0), target (10,0,3), jump_en=0, accepted at T -> velocity X/Y/Z is 4/0/3 on T+1, 4/0/0 on T+2, 2/0/0 on T+3, 0 on T+4. done=1 only on T+5; cur_position=(10,0,3); cmd_ready=1 on T+6.
3. Wrap: from (0,0,0), target (0xFFFE,0,0) -> velocity X=0xFFFE for one cycle. cur_position X=0xFFFE, then done.
4. Jump: target (1000,0,0), jump_en=1 -> T+1 pos_mode=0100, jump_position={1000,0,0}. T+2 done=1, cur_position X=1000. Same command with target X=50 -> CRUISE stepping, no 0100 cycle.
5. Abort/reset: abort on the T+2 cruise cycle of scenario 2 -> next cycle IDLE, velocity=0, cur_position=(8,0,3), no done. Repeat with rst instead -> ZERO cycle, cur_position=0.
6. cmd_valid pulsed with target (50,50,50) during CRUISE -> ignored; original target reached, one done pulse only.
